// File: rtl/mem_stage.sv
// mem_stage -- memory stage of the 5-stage pipelined CPU.
//
// Holds the EX/MEM pipeline register, performs byte/half/word loads and
// stores over a req/ack data bus, and drives the MEM/WB register. While a
// bus access is outstanding, mem_stall freezes the upstream stages.
//
// Ports:
//   clk, rst           pipeline clock (rising edge), async active-high reset
//   ex_*               execute-stage result captured into the EX/MEM register
//   flush              capture a bubble instead of the ex_* inputs
//   mem_stall          combinational freeze request to upstream stages
//   bus_*              registered req/ack data bus (word-aligned address,
//                      little-endian byte enables)
//   bus_rdata/bus_ack  read data and completion, sampled in the ack cycle
//   wb_*               MEM/WB register outputs
//   misalign_exc       one-cycle pulse alongside a killed misaligned access
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       ex_alu_out,
    input  logic [31:0]       ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_size,
    input  logic              ex_load_unsigned,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_wreg,
    input  logic              flush,
    output logic              mem_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_wreg,
    output logic [31:0]       wb_data,
    output logic              misalign_exc
);

    typedef enum logic {IDLE, BUS} state_t;

    state_t      state, state_next;

    logic        m_valid;
    logic [31:0] m_alu_out;
    logic [31:0] m_store_data;
    logic        m_mem_read;
    logic        m_mem_write;
    logic [1:0]  m_size;
    logic        m_load_unsigned;
    logic        m_reg_write;
    logic [4:0]  m_wreg;

    logic        memop;
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_val;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // EX/MEM register: holds while stalled; flush only matters when loading.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid         <= 1'b0;
            m_alu_out       <= '0;
            m_store_data    <= '0;
            m_mem_read      <= 1'b0;
            m_mem_write     <= 1'b0;
            m_size          <= '0;
            m_load_unsigned <= 1'b0;
            m_reg_write     <= 1'b0;
            m_wreg          <= '0;
        end else if (!mem_stall) begin
            m_valid         <= ex_valid & ~flush;
            m_alu_out       <= ex_alu_out;
            m_store_data    <= ex_store_data;
            m_mem_read      <= ex_mem_read;
            m_mem_write     <= ex_mem_write;
            m_size          <= ex_size;
            m_load_unsigned <= ex_load_unsigned;
            m_reg_write     <= ex_reg_write;
            m_wreg          <= ex_wreg;
        end
    end

    assign memop = m_valid & (m_mem_read | m_mem_write);

    // Size 11 behaves as word, so size[1] alone selects the word check.
    // Alignment only matters for memory ops; ALU results may be odd.
    assign misaligned = memop &
        (((m_size == 2'b01) & m_alu_out[0]) | (m_size[1] & (m_alu_out[1:0] != 2'b00)));

    assign mem_stall = memop & ~misaligned & ~((state == BUS) & bus_ack);

    // Byte-lane steering for stores; loads use the same enables.
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = m_store_data;
        case (m_size)
            2'b00: begin
                lane_be    = 4'b0001 << m_alu_out[1:0];
                lane_wdata = {4{m_store_data[7:0]}};
            end
            2'b01: begin
                lane_be    = m_alu_out[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{m_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction: select lane by address, then sign/zero extend.
    always_comb begin
        load_byte = bus_rdata[7:0];
        case (m_alu_out[1:0])
            2'b01:   load_byte = bus_rdata[15:8];
            2'b10:   load_byte = bus_rdata[23:16];
            2'b11:   load_byte = bus_rdata[31:24];
            default: ;
        endcase
        load_half = m_alu_out[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_val  = bus_rdata;
        case (m_size)
            2'b00: load_val = m_load_unsigned ? {24'd0, load_byte}
                                              : {{24{load_byte[7]}}, load_byte};
            2'b01: load_val = m_load_unsigned ? {16'd0, load_half}
                                              : {{16{load_half[15]}}, load_half};
            default: ;
        endcase
    end

    // FSM: one IDLE cycle per memory op, then BUS until acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (memop & ~misaligned) state_next = BUS;
            BUS:  if (bus_ack)             state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are registered: loaded on entry to BUS, held until the
    // ack edge, then cleared so they read 0 in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else if ((state == IDLE) && (state_next == BUS)) begin
            bus_req   <= 1'b1;
            bus_we    <= m_mem_write;
            bus_addr  <= {m_alu_out[ADDR_W-1:2], 2'b00};
            bus_be    <= lane_be;
            bus_wdata <= lane_wdata;
        end else if ((state == BUS) && bus_ack) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end
    end

    // MEM/WB register: a stall inserts a bubble; a misaligned op becomes a
    // bubble flagged by misalign_exc in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_wreg      <= '0;
            wb_data      <= '0;
            misalign_exc <= 1'b0;
        end else begin
            wb_valid     <= ~mem_stall & m_valid & ~misaligned;
            wb_reg_write <= ~mem_stall & m_valid & ~misaligned & m_reg_write;
            wb_wreg      <= m_wreg;
            wb_data      <= m_mem_read ? load_val : m_alu_out;
            misalign_exc <= ~mem_stall & misaligned;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_load_unsigned;
    logic        ex_reg_write;
    logic [4:0]  ex_wreg;
    logic        flush;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_wreg;
    logic [31:0] wb_data;
    logic        misalign_exc;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_size(ex_size),
        .ex_load_unsigned(ex_load_unsigned), .ex_reg_write(ex_reg_write),
        .ex_wreg(ex_wreg), .flush(flush),
        .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg),
        .wb_data(wb_data), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex();
        ex_valid = 0; ex_alu_out = 0; ex_store_data = 0; ex_mem_read = 0;
        ex_mem_write = 0; ex_size = 0; ex_load_unsigned = 0; ex_reg_write = 0;
        ex_wreg = 0; flush = 0;
    endtask

    task automatic drive_ex(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic rw, input logic [4:0] wreg,
                            input logic [31:0] alu, input logic [31:0] sdata);
        ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_size = sz;
        ex_load_unsigned = uns; ex_reg_write = rw; ex_wreg = wreg;
        ex_alu_out = alu; ex_store_data = sdata; flush = 0;
    endtask

    // Called one cycle after the memory op entered EX/MEM (its IDLE cycle).
    // Walks IDLE, lat BUS cycles without ack, then the ack cycle; returns
    // just after the ack edge, where MEM/WB holds the result.
    task automatic run_memop(input string name, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int lat);
        int stalls;
        logic [69:0] exp_bus;
        exp_bus = {1'b1, we, addr, be, wdata};
        stalls = 0;
        n_cmp++;
        if (bus_req !== 1'b0) begin
            n_err++; $display("FAIL %s idle_req: got %b want 0", name, bus_req);
        end
        if (mem_stall) stalls++;
        step();
        for (int i = 0; i < lat; i++) begin
            n_cmp++;
            if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== exp_bus) begin
                n_err++;
                $display("FAIL %s bus_cycle%0d: got %h want %h", name, i,
                         {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, exp_bus);
            end
            if (mem_stall) stalls++;
            step();
        end
        bus_ack = 1; bus_rdata = rdata;
        #1;
        n_cmp++;
        if ({mem_stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b0, exp_bus}) begin
            n_err++;
            $display("FAIL %s ack_cycle: got %h want %h", name,
                     {mem_stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata}, {1'b0, exp_bus});
        end
        n_cmp++;
        if (stalls != lat + 1) begin
            n_err++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, lat + 1);
        end
        step();
        bus_ack = 0; bus_rdata = 32'h0;
        n_cmp++;
        if (bus_req !== 1'b0) begin
            n_err++; $display("FAIL %s req_after_ack: got %b want 0", name, bus_req);
        end
    endtask

    task automatic check_wb(input string name, input logic v, input logic rw,
                            input logic [4:0] wreg, input logic [31:0] data);
        n_cmp++;
        if ({wb_valid, wb_reg_write, wb_wreg, wb_data} !== {v, rw, wreg, data}) begin
            n_err++;
            $display("FAIL %s wb: got v=%b rw=%b r=%0d d=%h want v=%b rw=%b r=%0d d=%h",
                     name, wb_valid, wb_reg_write, wb_wreg, wb_data, v, rw, wreg, data);
        end
    endtask

    task automatic test_reset();
        rst = 1; idle_ex(); bus_ack = 0; bus_rdata = 0;
        #12;
        n_cmp++;
        if ({mem_stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata, wb_valid,
             wb_reg_write, wb_wreg, wb_data, misalign_exc} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero want all 0");
        end
        rst = 0;
        step();
    endtask

    task automatic test_alu();
        drive_ex(0, 0, 2'b00, 0, 1, 5'd5, 32'h0000_1234, 32'h0);
        step();
        idle_ex();
        n_cmp++;
        if (mem_stall !== 1'b0) begin
            n_err++; $display("FAIL alu_stall: got %b want 0", mem_stall);
        end
        step();
        check_wb("alu", 1, 1, 5'd5, 32'h0000_1234);
        n_cmp++;
        if (mem_stall !== 1'b0) begin
            n_err++; $display("FAIL alu_stall2: got %b want 0", mem_stall);
        end
    endtask

    task automatic test_lw();
        drive_ex(1, 0, 2'b10, 0, 1, 5'd7, 32'h0000_0100, 32'h0);
        step();
        idle_ex();
        run_memop("lw", 0, 32'h100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 3);
        check_wb("lw", 1, 1, 5'd7, 32'hDEAD_BEEF);
    endtask

    task automatic test_lb();
        drive_ex(1, 0, 2'b00, 0, 1, 5'd8, 32'h0000_0103, 32'h0);
        step();
        idle_ex();
        run_memop("lb", 0, 32'h100, 4'b1000, 32'h0, 32'h80FF_FFFF, 1);
        check_wb("lb", 1, 1, 5'd8, 32'hFFFF_FF80);
        drive_ex(1, 0, 2'b00, 1, 1, 5'd9, 32'h0000_0103, 32'h0);
        step();
        idle_ex();
        run_memop("lbu", 0, 32'h100, 4'b1000, 32'h0, 32'h80FF_FFFF, 1);
        check_wb("lbu", 1, 1, 5'd9, 32'h0000_0080);
    endtask

    task automatic test_store();
        drive_ex(0, 1, 2'b01, 0, 0, 5'd0, 32'h0000_0202, 32'h0000_ABCD);
        step();
        idle_ex();
        run_memop("sh", 1, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0, 2);
        check_wb("sh", 1, 0, 5'd0, 32'h0000_0202);
        drive_ex(0, 1, 2'b00, 0, 0, 5'd0, 32'h0000_0201, 32'h1234_565A);
        step();
        idle_ex();
        run_memop("sb", 1, 32'h200, 4'b0010, 32'h5A5A_5A5A, 32'h0, 1);
        check_wb("sb", 1, 0, 5'd0, 32'h0000_0201);
    endtask

    task automatic test_misalign();
        drive_ex(1, 0, 2'b10, 0, 1, 5'd3, 32'h0000_0101, 32'h0);
        step();
        drive_ex(0, 0, 2'b00, 0, 1, 5'd4, 32'h0000_0777, 32'h0);
        n_cmp++;
        if ({mem_stall, bus_req} !== 2'b00) begin
            n_err++; $display("FAIL mis_nostall: got %b want 00", {mem_stall, bus_req});
        end
        step();
        idle_ex();
        n_cmp++;
        if ({misalign_exc, wb_valid, bus_req} !== 3'b100) begin
            n_err++; $display("FAIL mis_exc: got %b want 100", {misalign_exc, wb_valid, bus_req});
        end
        step();
        n_cmp++;
        if (misalign_exc !== 1'b0) begin
            n_err++; $display("FAIL mis_pulse: got %b want 0", misalign_exc);
        end
        check_wb("mis_next_alu", 1, 1, 5'd4, 32'h0000_0777);
    endtask

    task automatic test_flush();
        drive_ex(1, 0, 2'b10, 0, 1, 5'd6, 32'h0000_0300, 32'h0);
        flush = 1;
        step();
        idle_ex();
        n_cmp++;
        if (mem_stall !== 1'b0) begin
            n_err++; $display("FAIL flush_stall: got %b want 0", mem_stall);
        end
        step();
        n_cmp++;
        if ({wb_valid, bus_req} !== 2'b00) begin
            n_err++; $display("FAIL flush_wb: got %b want 00", {wb_valid, bus_req});
        end
    endtask

    task automatic test_back_to_back();
        drive_ex(1, 0, 2'b10, 0, 1, 5'd10, 32'h0000_0100, 32'h0);
        step();
        drive_ex(1, 0, 2'b01, 0, 1, 5'd11, 32'h0000_0206, 32'h0);
        run_memop("b2b_lw", 0, 32'h100, 4'b1111, 32'h0, 32'h0BAD_F00D, 1);
        idle_ex();
        check_wb("b2b_lw", 1, 1, 5'd10, 32'h0BAD_F00D);
        n_cmp++;
        if (mem_stall !== 1'b1) begin
            n_err++; $display("FAIL b2b_second_stall: got %b want 1", mem_stall);
        end
        run_memop("b2b_lh", 0, 32'h204, 4'b1100, 32'h0, 32'h8001_1234, 1);
        check_wb("b2b_lh", 1, 1, 5'd11, 32'hFFFF_8001);
    endtask

    task automatic test_reset_mid_bus();
        drive_ex(1, 0, 2'b10, 0, 1, 5'd12, 32'h0000_0400, 32'h0);
        step();
        idle_ex();
        step();
        n_cmp++;
        if (bus_req !== 1'b1) begin
            n_err++; $display("FAIL rstbus_req_before: got %b want 1", bus_req);
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if ({mem_stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata, wb_valid,
             wb_reg_write, wb_wreg, wb_data, misalign_exc} !== '0) begin
            n_err++; $display("FAIL rstbus_outputs: got req=%b stall=%b want all 0", bus_req, mem_stall);
        end
        step();
        rst = 0;
        step();
        bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_ack = 0;
        n_cmp++;
        if ({wb_valid, bus_req, mem_stall} !== 3'b000) begin
            n_err++; $display("FAIL rstbus_late_ack: got %b want 000", {wb_valid, bus_req, mem_stall});
        end
        step();
        n_cmp++;
        if (wb_valid !== 1'b0) begin
            n_err++; $display("FAIL rstbus_late_ack2: got %b want 0", wb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw();
        test_lb();
        test_store();
        test_misalign();
        test_flush();
        test_back_to_back();
        test_reset_mid_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
